// File: rtl/softmax_pkg.sv
// softmax_pkg: state encoding and default sizes shared by the softmax layer blocks.
package softmax_pkg;
    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_DATA_SIZE = 128;
    typedef enum logic [2:0] {IDLE, NES_REQ, NES_RUN, DIV_REQ, DIV_RUN, DONE} softmax_state_t;
endpackage

// File: rtl/softmax_sched.sv
// softmax_sched: per-vector sequencer running norm_exp_sum, then divide, for each vector of a job.
// SOFTMAX_SCHED_TIMEOUT_EN adds a watchdog on both RUN states that flags job_err and ends the job.
module softmax_sched
    import softmax_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = DEFAULT_DW,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int BW = 5,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_start,
    input  logic [BW-1:0] job_num,
    input  logic [DW-1:0] job_scale,
    output logic          job_ready,
    output logic          job_done,
    output logic          job_err,
    input  logic          nes_ready,
    output logic          nes_start,
    output logic [DW-1:0] nes_scale,
    output logic [AW-1:0] nes_base,
    input  logic [DW-1:0] nes_sum,
    input  logic          nes_done,
    output logic          nes_downstream_ready,
    input  logic          div_ready,
    output logic          div_start,
    output logic [DW-1:0] div_sum,
    input  logic          div_done,
    output logic [BW-1:0] vec_idx
);
    softmax_state_t state;
    logic [BW-1:0] num_q;
    logic wd_hit;

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic wd_run;
    assign wd_run = (state == NES_RUN) || (state == DIV_RUN);
    assign wd_hit = wd_run && (wd_cnt == CW'(TIMEOUT - 1));
    // Counter sits at zero outside the RUN states, so every RUN entry starts a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            job_err <= 1'b0;
        end else begin
            wd_cnt <= wd_run ? wd_cnt + 1'b1 : '0;
            if (state == IDLE && job_start)
                job_err <= 1'b0;
            else if (wd_hit)
                job_err <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign job_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            num_q <= '0;
            job_ready <= 1'b1;
            job_done <= 1'b0;
            nes_start <= 1'b0;
            div_start <= 1'b0;
            nes_downstream_ready <= 1'b0;
            nes_scale <= '0;
            nes_base <= '0;
            div_sum <= '0;
            vec_idx <= '0;
        end else begin
            job_done <= 1'b0;
            nes_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: if (job_start) begin
                    num_q <= job_num;
                    nes_scale <= job_scale;
                    vec_idx <= '0;
                    nes_base <= '0;
                    job_ready <= 1'b0;
                    state <= (job_num == '0) ? DONE : NES_REQ;
                end
                NES_REQ: if (nes_ready) begin
                    nes_start <= 1'b1;
                    nes_downstream_ready <= 1'b1;
                    state <= NES_RUN;
                end
                // nes_start still high marks the first RUN cycle, where a done is a protocol error.
                NES_RUN: if (wd_hit) begin
                    nes_downstream_ready <= 1'b0;
                    state <= DONE;
                end else if (nes_done && !nes_start) begin
                    div_sum <= nes_sum;
                    nes_downstream_ready <= 1'b0;
                    state <= DIV_REQ;
                end
                DIV_REQ: if (div_ready) begin
                    div_start <= 1'b1;
                    state <= DIV_RUN;
                end
                DIV_RUN: if (wd_hit) begin
                    state <= DONE;
                end else if (div_done) begin
                    if (vec_idx == num_q - BW'(1)) begin
                        state <= DONE;
                    end else begin
                        vec_idx <= vec_idx + 1'b1;
                        nes_base <= nes_base + AW'(DATA_SIZE);
                        state <= NES_REQ;
                    end
                end
                DONE: begin
                    job_done <= 1'b1;
                    job_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_sched.sv
// tb_softmax_sched: randomized scoreboard bench for softmax_sched with stubbed norm_exp_sum and divide stages.
module tb_softmax_sched;
    localparam int AW = 12, DW = 32, DS = 128, BW = 5, TO = 64;

    logic clk = 0, rst = 1;
    logic job_start = 0;
    logic [BW-1:0] job_num = '0;
    logic [DW-1:0] job_scale = '0;
    logic job_ready, job_done, job_err;
    logic nes_ready = 1, nes_start, nes_done = 0, nes_downstream_ready;
    logic [DW-1:0] nes_scale, nes_sum = '0, div_sum;
    logic [AW-1:0] nes_base;
    logic div_ready = 1, div_start, div_done = 0;
    logic [BW-1:0] vec_idx;

    softmax_sched #(.AW(AW), .DW(DW), .DATA_SIZE(DS), .BW(BW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .job_start(job_start), .job_num(job_num), .job_scale(job_scale),
        .job_ready(job_ready), .job_done(job_done), .job_err(job_err),
        .nes_ready(nes_ready), .nes_start(nes_start), .nes_scale(nes_scale), .nes_base(nes_base),
        .nes_sum(nes_sum), .nes_done(nes_done), .nes_downstream_ready(nes_downstream_ready),
        .div_ready(div_ready), .div_start(div_start), .div_sum(div_sum), .div_done(div_done),
        .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        logic [DW-1:0] scale;
        logic [BW-1:0] idx;
    } nes_exp_t;

    nes_exp_t exp_nes[$];
    logic [DW-1:0] exp_div[$];
    logic [DW-1:0] sum_src[$];
    logic exp_done[$];
    nes_exp_t e_mon;

    int checks = 0, errors = 0, cyc = 0, done_due = -1;
    int nes_delay = 20, div_delay = 5, nes_cnt = -1, div_cnt = -1;
    bit nes_hang = 0, early = 0, wd_test = 0;
    logic ndr_m = 0, prev_ns = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // norm_exp_sum stub: answers each start after nes_delay cycles, optionally with an illegal early done.
    initial forever begin
        @(negedge clk);
        nes_done = 0;
        if (rst) begin
            nes_cnt = -1;
        end else if (nes_start) begin
            if (early) begin
                nes_done = 1;
                nes_sum = $urandom;
            end
            if (!nes_hang) nes_cnt = nes_delay;
        end else if (nes_cnt > 0) begin
            nes_cnt--;
        end
        if (nes_cnt == 0) begin
            nes_sum = (sum_src.size() > 0) ? sum_src.pop_front() : $urandom;
            exp_div.push_back(nes_sum);
            nes_done = 1;
            nes_cnt = -1;
        end
    end

    initial forever begin
        @(negedge clk);
        div_done = 0;
        if (rst) div_cnt = -1;
        else if (div_start) div_cnt = div_delay;
        else if (div_cnt > 0) div_cnt--;
        if (div_cnt == 0) begin
            div_done = 1;
            div_cnt = -1;
        end
    end

    // Monitor: at each cycle sees outputs after edge N and the inputs the DUT sampled at edge N.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ndr_m = 0;
            prev_ns = 0;
            done_due = -1;
        end else begin
            if (nes_start) begin
                if (exp_nes.size() == 0) check("nes_start_unexpected", nes_start, 0);
                else begin
                    e_mon = exp_nes.pop_front();
                    check("nes_base", nes_base, e_mon.base);
                    check("nes_scale", nes_scale, e_mon.scale);
                    check("vec_idx", vec_idx, e_mon.idx);
                end
            end
            if (div_start) begin
                if (exp_div.size() == 0) check("div_start_unexpected", div_start, 0);
                else check("div_sum", div_sum, exp_div.pop_front());
            end
            if (job_done) begin
                if (exp_done.size() == 0) check("job_done_unexpected", job_done, 0);
                else check("job_err_at_done", job_err, exp_done.pop_front());
                if (done_due >= 0) check("job_done_latency", cyc, done_due);
                done_due = -1;
            end
            if (div_done && exp_nes.size() == 0) done_due = cyc + 1;
            if (nes_start) ndr_m = 1;
            else if (job_done || (nes_done && !prev_ns)) ndr_m = 0;
            if (!wd_test) check("nes_downstream_ready", nes_downstream_ready, ndr_m);
            prev_ns = nes_start;
        end
    end

    task automatic start_job(input int n, input logic [DW-1:0] s);
        nes_exp_t e;
        @(negedge clk);
        job_start = 1;
        job_num = BW'(n);
        job_scale = s;
        for (int i = 0; i < n; i++) begin
            e.base = AW'(i * DS);
            e.scale = s;
            e.idx = BW'(i);
            exp_nes.push_back(e);
        end
        exp_done.push_back(1'b0);
        @(negedge clk);
        job_start = 0;
    endtask

    task automatic wait_done(input int lim);
        int i = 0;
        while (!job_done && i < lim) begin
            @(negedge clk);
            i++;
        end
        check("job_done_seen", job_done, 1);
        check("job_ready_with_done", job_ready, 1);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_job_ready"}, job_ready, 1);
        check({tag, "_job_done"}, job_done, 0);
        check({tag, "_job_err"}, job_err, 0);
        check({tag, "_nes_start"}, nes_start, 0);
        check({tag, "_div_start"}, div_start, 0);
        check({tag, "_nes_base"}, nes_base, 0);
        check({tag, "_nes_scale"}, nes_scale, 0);
        check({tag, "_div_sum"}, div_sum, 0);
        check({tag, "_vec_idx"}, vec_idx, 0);
        check({tag, "_ndr"}, nes_downstream_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, i;
        logic seen;
        logic [DW-1:0] s;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 0;

        // Basic three-vector job with fixed sums
        sum_src.push_back(32'h3F800000);
        sum_src.push_back(32'h40000000);
        sum_src.push_back(32'h40400000);
        start_job(3, 32'h3DCCCCCD);
        check("job_ready_fall", job_ready, 0);
        check("no_start_at_accept", nes_start, 0);
        @(negedge clk);
        check("first_nes_start", nes_start, 1);
        wait_done(500);

        // Empty job
        start_job(0, $urandom);
        check("empty_done_not_early", job_done, 0);
        @(negedge clk);
        check("empty_done", job_done, 1);
        @(negedge clk);

        // Backpressure on both stages
        nes_ready = 0;
        start_job(2, $urandom);
        seen = 0;
        repeat (50) begin @(negedge clk); seen |= nes_start; end
        check("nes_start_held", seen, 0);
        nes_ready = 1;
        @(negedge clk);
        check("nes_start_after_ready", nes_start, 1);
        div_ready = 0;
        seen = 0;
        repeat (50) begin @(negedge clk); seen |= div_start; end
        check("div_start_held", seen, 0);
        div_ready = 1;
        @(negedge clk);
        check("div_start_after_ready", div_start, 1);
        wait_done(500);

        // Early done ignored, job_start ignored while busy
        early = 1;
        start_job(2, 32'h11111111);
        i = 0;
        while (!nes_start && i < 20) begin @(negedge clk); i++; end
        check("early_nes_start_seen", nes_start, 1);
        @(negedge clk);
        job_start = 1;
        job_num = 7;
        job_scale = 32'h22222222;
        @(negedge clk);
        job_start = 0;
        check("ignored_start_scale", nes_scale, 32'h11111111);
        check("ignored_start_ready", job_ready, 0);
        wait_done(500);
        early = 0;

        // Reset in DIV_RUN of vector 1
        div_delay = 10;
        start_job(3, $urandom);
        n = 0;
        i = 0;
        while (n < 2 && i < 400) begin
            @(negedge clk);
            if (div_start) n++;
            i++;
        end
        check("reached_vec1_div", n, 2);
        check("vec1_idx", vec_idx, 1);
        #2 rst = 1;
        #1 check_reset("midjob");
        exp_nes.delete();
        exp_div.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);

        // Randomized jobs
        repeat (5) begin
            nes_delay = $urandom_range(1, 40);
            div_delay = $urandom_range(1, 30);
            start_job($urandom_range(1, 31), $urandom);
            wait_done(4000);
        end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
        // Watchdog: norm_exp_sum never finishes
        wd_test = 1;
        nes_hang = 1;
        s = $urandom;
        @(negedge clk);
        job_start = 1;
        job_num = 3;
        job_scale = s;
        e_mon.base = '0;
        e_mon.scale = s;
        e_mon.idx = '0;
        exp_nes.push_back(e_mon);
        exp_done.push_back(1'b1);
        @(negedge clk);
        job_start = 0;
        @(negedge clk);
        check("wd_nes_start", nes_start, 1);
        repeat (64) @(negedge clk);
        check("wd_not_done_yet", job_done, 0);
        @(negedge clk);
        check("wd_done", job_done, 1);
        check("wd_err", job_err, 1);
        @(negedge clk);
        nes_hang = 0;
        wd_test = 0;
        check("wd_err_sticky", job_err, 1);
        start_job(1, $urandom);
        check("wd_err_cleared", job_err, 0);
        wait_done(500);
`endif

        check("exp_nes_left", exp_nes.size(), 0);
        check("exp_div_left", exp_div.size(), 0);
        check("exp_done_left", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
